// File: rtl/pwm_led_pkg.sv
// -----------------------------------------------------------------------------
// pwm_led_pkg
// Shared definitions for the multi-channel LED PWM block: mode encodings, the
// per-channel fade state encoding and the saturating fade step helper.
// -----------------------------------------------------------------------------
package pwm_led_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_FADE   = 1'b1;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        FADE_UP = 2'd1,
        FADE_DN = 2'd2
    } chanState_t;

    // One fade step of 'active' toward 'target', clamped so it never overshoots.
    // Operands are zero-extended duty values; the add is done one bit wider so
    // a carry out of the duty width is seen as "past the target".
    function automatic logic [31:0] fade_next(input logic [31:0] active,
                                              input logic [31:0] target,
                                              input logic [31:0] step);
        logic [32:0] sum;
        logic [31:0] result;
        sum = {1'b0, active} + {1'b0, step};
        if (active < target) begin
            if (sum > {1'b0, target}) begin
                result = target;
            end else begin
                result = sum[31:0];
            end
        end else if (active > target) begin
            if ((active < step) || ((active - step) < target)) begin
                result = target;
            end else begin
                result = active - step;
            end
        end else begin
            result = active;
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_led_if.sv
// -----------------------------------------------------------------------------
// pwm_led_if
// Control/status bundle between the register logic (master) and the PWM block
// (slave).
//   DutyCycle   per-channel duty, channel i at [i*WIDTH +: WIDTH]
//   Load        strobe: capture DutyCycle into every channel target
//   Mode        per-channel 0 = direct, 1 = fade
//   FadeStep    shared duty change per period in fade mode
//   PWM         registered LED drive outputs
//   PeriodStart one-cycle pulse on the first PWM cycle of a period
//   Fading      per-channel "ramp in progress"
// -----------------------------------------------------------------------------
interface pwm_led_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    logic [CHANNELS*WIDTH-1:0] DutyCycle;
    logic                      Load;
    logic [CHANNELS-1:0]       Mode;
    logic [WIDTH-1:0]          FadeStep;
    logic [CHANNELS-1:0]       PWM;
    logic                      PeriodStart;
    logic [CHANNELS-1:0]       Fading;

    modport master (
        output DutyCycle, Load, Mode, FadeStep,
        input  PWM, PeriodStart, Fading
    );

    modport slave (
        input  DutyCycle, Load, Mode, FadeStep,
        output PWM, PeriodStart, Fading
    );
endinterface

// File: rtl/pwm_led_chan.sv
// -----------------------------------------------------------------------------
// pwm_led_chan
// One PWM channel: target/active duty registers, fade state machine, compare
// against the shared counter and the registered LED output.
//   SysClk, ResetN  clock, asynchronous active-low reset
//   dutyIn, load    new target and its capture strobe
//   mode, fadeStep  direct/fade selection and fade increment
//   cnt, boundary   shared period counter and its wrap event
//   pwm, fading     registered channel outputs
// -----------------------------------------------------------------------------
module pwm_led_chan import pwm_led_pkg::*; #(
    parameter int WIDTH       = 8,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic             SysClk,
    input  logic             ResetN,
    input  logic [WIDTH-1:0] dutyIn,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] fadeStep,
    input  logic [WIDTH-1:0] cnt,
    input  logic             boundary,
    output logic             pwm,
    output logic             fading
);

    localparam logic OFF_LEVEL = ACTIVE_HIGH ? 1'b0 : 1'b1;

    logic [WIDTH-1:0] targetR;
    logic [WIDTH-1:0] activeR;
    logic [WIDTH-1:0] targetNextS;
    logic [WIDTH-1:0] activeNextS;
    logic [31:0]      fadeCalcS;
    logic             unusedFadeS;
    chanState_t       stateR;
    chanState_t       stateNextS;
    logic             pwmR;
    logic             fadingR;

    // The fade result never exceeds max(active, target), so only the low bits matter.
    assign unusedFadeS = ^fadeCalcS;

    // Next target/active: the boundary works from the target held before this edge,
    // so a Load on the boundary edge lands one period later.
    always_comb begin
        fadeCalcS   = fade_next(32'(activeR), 32'(targetR), 32'(fadeStep));
        targetNextS = load ? dutyIn : targetR;
        activeNextS = activeR;
        if (boundary) begin
            if (mode == MODE_FADE) begin
                activeNextS = fadeCalcS[WIDTH-1:0];
            end else begin
                activeNextS = targetR;
            end
        end else begin
            activeNextS = activeR;
        end
    end

    // Fade state machine, re-evaluated every edge against the values being registered.
    always_comb begin
        stateNextS = HOLD;
        case (stateR)
            HOLD: begin
                if ((mode == MODE_FADE) && (targetNextS > activeNextS)) begin
                    stateNextS = FADE_UP;
                end else if ((mode == MODE_FADE) && (targetNextS < activeNextS)) begin
                    stateNextS = FADE_DN;
                end else begin
                    stateNextS = HOLD;
                end
            end
            FADE_UP, FADE_DN: begin
                if ((mode != MODE_FADE) || (targetNextS == activeNextS)) begin
                    stateNextS = HOLD;
                end else if (targetNextS > activeNextS) begin
                    stateNextS = FADE_UP;
                end else begin
                    stateNextS = FADE_DN;
                end
            end
            default: begin
                stateNextS = HOLD;
            end
        endcase
    end

    // Channel registers; the output compare uses the counter value of this cycle,
    // so PWM trails the counter by one clock.
    always_ff @(posedge SysClk or negedge ResetN) begin
        if (!ResetN) begin
            targetR <= '0;
            activeR <= '0;
            stateR  <= HOLD;
            pwmR    <= OFF_LEVEL;
            fadingR <= 1'b0;
        end else begin
            targetR <= targetNextS;
            activeR <= activeNextS;
            stateR  <= stateNextS;
            pwmR    <= (cnt < activeR) ^ OFF_LEVEL;
            fadingR <= (stateNextS != HOLD);
        end
    end

    assign pwm    = pwmR;
    assign fading = fadingR;

endmodule

// File: rtl/pwm_led_multi.sv
// -----------------------------------------------------------------------------
// pwm_led_multi
// Multi-channel LED PWM generator. One prescaled period counter is shared by
// all channels; each channel applies new duty values only at the period wrap.
//   SysClk  system clock (rising edge)
//   ResetN  asynchronous active-low reset
//   bus     pwm_led_if slave: DutyCycle/Load/Mode/FadeStep in,
//           PWM/PeriodStart/Fading out (all registered)
// -----------------------------------------------------------------------------
module pwm_led_multi import pwm_led_pkg::*; #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int PRESCALE    = 1,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic     SysClk,
    input  logic     ResetN,
    pwm_led_if.slave bus
);

    localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]    preR;
    logic [WIDTH-1:0]    cntR;
    logic                tickS;
    logic                boundaryS;
    logic                boundaryDlyR;
    logic                periodStartR;
    logic [CHANNELS-1:0] pwmS;
    logic [CHANNELS-1:0] fadingS;

    assign tickS     = (preR == PRE_LAST);
    assign boundaryS = tickS && (cntR == {WIDTH{1'b1}});

    // Prescaler, period counter and PeriodStart. PeriodStart trails the wrap by two
    // edges: one for the counter to reach 0, one for the PWM output register.
    always_ff @(posedge SysClk or negedge ResetN) begin
        if (!ResetN) begin
            preR         <= '0;
            cntR         <= '0;
            boundaryDlyR <= 1'b0;
            periodStartR <= 1'b0;
        end else begin
            if (tickS) begin
                preR <= '0;
                cntR <= cntR + 1'b1;
            end else begin
                preR <= preR + 1'b1;
                cntR <= cntR;
            end
            boundaryDlyR <= boundaryS;
            periodStartR <= boundaryDlyR;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : gChan
        pwm_led_chan #(
            .WIDTH       (WIDTH),
            .ACTIVE_HIGH (ACTIVE_HIGH)
        ) uChan (
            .SysClk   (SysClk),
            .ResetN   (ResetN),
            .dutyIn   (bus.DutyCycle[i*WIDTH +: WIDTH]),
            .load     (bus.Load),
            .mode     (bus.Mode[i]),
            .fadeStep (bus.FadeStep),
            .cnt      (cntR),
            .boundary (boundaryS),
            .pwm      (pwmS[i]),
            .fading   (fadingS[i])
        );
    end

    assign bus.PWM         = pwmS;
    assign bus.Fading      = fadingS;
    assign bus.PeriodStart = periodStartR;

endmodule

// File: tb/tb_pwm_led_multi.sv
// -----------------------------------------------------------------------------
// tb_pwm_led_multi
// Self-checking bench: a default instance (4 ch, 8 bit, PRESCALE 1, active high)
// and an inverted, prescaled instance (PRESCALE 3, active low).
// -----------------------------------------------------------------------------
module tb_pwm_led_multi;

    localparam int CH  = 4;
    localparam int W   = 8;
    localparam int PER = 256;

    typedef struct {
        logic [CH*W-1:0] duty;
        int              expHi [CH];
    } dvec_t;

    typedef struct {
        int   hi;
        logic fad;
    } fvec_t;

    logic SysClk = 1'b0;
    logic ResetN = 1'b0;
    always #5 SysClk = ~SysClk;

    pwm_led_if #(.CHANNELS(CH), .WIDTH(W)) bus ();
    pwm_led_if #(.CHANNELS(CH), .WIDTH(W)) bus2 ();

    pwm_led_multi #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(1), .ACTIVE_HIGH(1'b1)) dut (
        .SysClk (SysClk),
        .ResetN (ResetN),
        .bus    (bus.slave)
    );

    pwm_led_multi #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(3), .ACTIVE_HIGH(1'b0)) dut2 (
        .SysClk (SysClk),
        .ResetN (ResetN),
        .bus    (bus2.slave)
    );

    int          nChecks = 0;
    int          nFail   = 0;
    int          hiCnt [CH];
    logic [CH-1:0] fadeFirst;
    dvec_t       dirTab [3];
    fvec_t       upTab [8];
    fvec_t       dnTab [3];

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance (on negedges) until PeriodStart of the default instance is seen.
    task automatic wait_ps();
        int k;
        k = 0;
        while (bus.PeriodStart !== 1'b1 && k < 1000) begin
            @(negedge SysClk);
            k++;
        end
        if (bus.PeriodStart !== 1'b1) check("ps_timeout", int'(bus.PeriodStart), 1);
    endtask

    task automatic wait_ps2();
        int k;
        k = 0;
        while (bus2.PeriodStart !== 1'b1 && k < 2000) begin
            @(negedge SysClk);
            k++;
        end
        if (bus2.PeriodStart !== 1'b1) check("ps2_timeout", int'(bus2.PeriodStart), 1);
    endtask

    // Count high cycles per channel over one full period starting at PeriodStart.
    // If loadAt >= 0, a Load of loadVal is issued at that sample.
    task automatic measure(input int loadAt, input logic [CH*W-1:0] loadVal);
        wait_ps();
        fadeFirst = bus.Fading;
        for (int c = 0; c < CH; c++) hiCnt[c] = 0;
        for (int j = 0; j < PER; j++) begin
            for (int c = 0; c < CH; c++) hiCnt[c] += int'(bus.PWM[c]);
            if (j == loadAt) begin
                bus.DutyCycle = loadVal;
                bus.Load      = 1'b1;
            end else begin
                bus.Load = 1'b0;
            end
            @(negedge SysClk);
        end
    endtask

    // Load a new duty word a few cycles into the current period.
    task automatic load_mid(input logic [CH*W-1:0] val);
        wait_ps();
        repeat (10) @(negedge SysClk);
        bus.DutyCycle = val;
        bus.Load      = 1'b1;
        @(negedge SysClk);
        bus.Load      = 1'b0;
    endtask

    initial begin
        int k;
        int lowCnt;
        int onCnt;

        dirTab[0].duty = {8'd255, 8'd128, 8'd1,   8'd0};   dirTab[0].expHi = '{0, 1, 128, 255};
        dirTab[1].duty = {8'd3,   8'd64,  8'd0,   8'd255}; dirTab[1].expHi = '{255, 0, 64, 3};
        dirTab[2].duty = {8'd128, 8'd0,   8'd200, 8'd10};  dirTab[2].expHi = '{10, 200, 0, 128};
        upTab = '{'{16, 1'b1}, '{32, 1'b1}, '{48, 1'b1}, '{64, 1'b1},
                  '{80, 1'b1}, '{96, 1'b1}, '{100, 1'b0}, '{100, 1'b0}};
        dnTab = '{'{60, 1'b1}, '{20, 1'b1}, '{0, 1'b0}};

        bus.DutyCycle  = '0; bus.Load  = 1'b0; bus.Mode  = 4'b0000; bus.FadeStep  = 8'd0;
        bus2.DutyCycle = '0; bus2.Load = 1'b0; bus2.Mode = 4'b0000; bus2.FadeStep = 8'd0;

        // Reset state
        repeat (3) @(negedge SysClk);
        check("rst_pwm",    int'(bus.PWM), 0);
        check("rst_ps",     int'(bus.PeriodStart), 0);
        check("rst_fading", int'(bus.Fading), 0);
        check("rst_pwm_inv", int'(bus2.PWM), 15);
        ResetN = 1'b1;

        // Direct duties, table driven
        for (int v = 0; v < 3; v++) begin
            load_mid(dirTab[v].duty);
            measure(-1, '0);
            for (int c = 0; c < CH; c++) check($sformatf("direct_v%0d_ch%0d", v, c), hiCnt[c], dirTab[v].expHi[c]);
        end

        // Mid-period reload on ch1
        load_mid({8'd0, 8'd0, 8'd128, 8'd0});
        measure(-1, '0);
        check("reload_before", hiCnt[1], 128);
        measure(49, {8'd0, 8'd0, 8'd32, 8'd0});
        check("reload_current", hiCnt[1], 128);
        measure(-1, '0);
        check("reload_next", hiCnt[1], 32);

        // Fade up on ch2, step 16, 0 -> 100
        bus.Mode     = 4'b0100;
        bus.FadeStep = 8'd16;
        load_mid({8'd0, 8'd100, 8'd0, 8'd0});
        for (int p = 0; p < 8; p++) begin
            measure(-1, '0);
            check($sformatf("fade_up_p%0d", p), hiCnt[2], upTab[p].hi);
            check($sformatf("fade_up_flag_p%0d", p), int'(fadeFirst[2]), int'(upTab[p].fad));
        end

        // Fade down on ch2, step 40, 100 -> 0
        bus.FadeStep = 8'd40;
        load_mid({8'd0, 8'd0, 8'd0, 8'd0});
        for (int p = 0; p < 3; p++) begin
            measure(-1, '0);
            check($sformatf("fade_dn_p%0d", p), hiCnt[2], dnTab[p].hi);
            check($sformatf("fade_dn_flag_p%0d", p), int'(fadeFirst[2]), int'(dnTab[p].fad));
        end

        // Load on the boundary edge (ch1 direct): applied one period late
        load_mid({8'd0, 8'd0, 8'd50, 8'd0});
        measure(-1, '0);
        check("bload_setup", hiCnt[1], 50);
        measure(254, {8'd0, 8'd0, 8'd200, 8'd0});
        check("bload_same", hiCnt[1], 50);
        measure(-1, '0);
        check("bload_old", hiCnt[1], 50);
        measure(-1, '0);
        check("bload_new", hiCnt[1], 200);

        // FadeStep 0: holds while Fading stays set
        bus.FadeStep = 8'd0;
        load_mid({8'd0, 8'd80, 8'd200, 8'd0});
        for (int p = 0; p < 2; p++) begin
            measure(-1, '0);
            check($sformatf("step0_hi_p%0d", p), hiCnt[2], 0);
            check($sformatf("step0_flag_p%0d", p), int'(fadeFirst[2]), 1);
        end

        // Asynchronous reset in the middle of a period
        load_mid({8'd128, 8'd80, 8'd128, 8'd128});
        measure(-1, '0);
        check("prereset_hi", hiCnt[0], 128);
        repeat (100) @(negedge SysClk);
        check("prereset_pwm",    int'(bus.PWM), 11);
        check("prereset_fading", int'(bus.Fading), 4);
        ResetN = 1'b0;
        #1;
        check("async_rst_pwm",    int'(bus.PWM), 0);
        check("async_rst_ps",     int'(bus.PeriodStart), 0);
        check("async_rst_fading", int'(bus.Fading), 0);
        check("async_rst_inv",    int'(bus2.PWM), 15);
        @(negedge SysClk);
        ResetN = 1'b1;
        k = 0;
        while (bus.PeriodStart !== 1'b1 && k < 1000) begin
            @(negedge SysClk);
            k++;
        end
        check("first_ps_delay", k, 257);
        measure(-1, '0);
        check("post_reset_hi",     hiCnt[0], 0);
        check("post_reset_fading", int'(fadeFirst), 0);

        // Prescaled, inverted instance: duty 64 then duty 0
        bus2.DutyCycle = {8'd64, 8'd64, 8'd64, 8'd64};
        bus2.Load      = 1'b1;
        @(negedge SysClk);
        bus2.Load      = 1'b0;
        wait_ps2();
        @(negedge SysClk);
        wait_ps2();
        k = 0;
        lowCnt = 0;
        do begin
            lowCnt += (bus2.PWM[0] == 1'b0) ? 1 : 0;
            @(negedge SysClk);
            k++;
        end while (bus2.PeriodStart !== 1'b1 && k < 2000);
        check("inv_period_len", k, 768);
        check("inv_low_cycles", lowCnt, 192);

        bus2.DutyCycle = '0;
        bus2.Load      = 1'b1;
        @(negedge SysClk);
        bus2.Load      = 1'b0;
        wait_ps2();
        onCnt = 0;
        for (int j = 0; j < 768; j++) begin
            onCnt += (bus2.PWM == 4'hF) ? 1 : 0;
            @(negedge SysClk);
        end
        check("inv_duty0_high", onCnt, 768);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
